vend_credit_fsm: RTL and testbench

//  Parametrised vending controller: accumulates coin credit, vends one of NPROD products
//  at per-product prices, and returns change serially, one coin per ready/valid handshake.

---
 rtl/vend_credit_fsm.sv | 167 ++++++++++++++++
 tb/tb_vend_credit_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module   : vend_credit_fsm
// Brief    : Coin-credit vending controller with serial change payout.
// Revision : 1.0 - initial release
// ============================================================================
module vend_credit_fsm #(
  parameter int                  W          = 8,
  parameter int                  NPROD      = 4,
  parameter logic [NPROD*W-1:0]  PRICES     = {8'd7, 8'd5, 8'd3, 8'd2},
  parameter int                  MAX_CREDIT = 20,
  parameter int                  CHG_BIG    = 5,
  localparam int                 IW         = $clog2(NPROD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin_valid,
  input  logic [W-1:0]  coin_val,
  input  logic          sel_valid,
  input  logic [IW-1:0] sel_idx,
  input  logic          cancel,
  input  logic          chg_ready,
  output logic [W-1:0]  credit,
  output logic          vend_valid,
  output logic [IW-1:0] vend_idx,
  output logic          short_err,
  output logic          coin_reject,
  output logic          chg_valid,
  output logic [W-1:0]  chg_coin
);

  localparam int         c_ntab       = 2 ** IW;
  localparam logic [W:0] c_max_credit = (W+1)'(MAX_CREDIT);
  localparam logic [W-1:0] c_chg_big  = W'(CHG_BIG);
  localparam logic [W-1:0] c_chg_one  = W'(1);

  typedef enum logic [0:0] {
    ST_CREDIT = 1'b0,
    ST_CHANGE = 1'b1
  } state_t;

  state_t          r_state, w_state_d;
  logic [W-1:0]    r_credit, w_credit_d;
  logic            r_vend_valid, w_vend_valid_d;
  logic [IW-1:0]   r_vend_idx, w_vend_idx_d;
  logic            r_short_err, w_short_err_d;
  logic            r_coin_reject, w_coin_reject_d;
  logic            r_chg_valid, w_chg_valid_d;
  logic [W-1:0]    r_chg_coin, w_chg_coin_d;

  // Table padded to a power of two so any sel_idx value can index it safely.
  logic [W-1:0]    w_price_tab [c_ntab];
  logic [c_ntab-1:0] w_idx_ok;
  logic [W-1:0]    w_price;
  logic [W:0]      w_sum;
  logic [W-1:0]    w_after_vend;
  logic [W-1:0]    w_after_chg;

  generate
    for (genvar i = 0; i < c_ntab; i++) begin : g_tab
      if (i < NPROD) begin : g_real
        assign w_price_tab[i] = PRICES[i*W +: W];
        assign w_idx_ok[i]    = 1'b1;
      end else begin : g_pad
        assign w_price_tab[i] = '0;
        assign w_idx_ok[i]    = 1'b0;
      end
    end
  endgenerate

  function automatic logic [W-1:0] f_coin_for(input logic [W-1:0] c);
    return (c >= c_chg_big) ? c_chg_big : c_chg_one;
  endfunction

  assign w_price      = w_price_tab[sel_idx];
  assign w_sum        = {1'b0, r_credit} + {1'b0, coin_val};
  assign w_after_vend = r_credit - w_price;
  assign w_after_chg  = r_credit - r_chg_coin;

  always_comb begin
    w_state_d       = r_state;
    w_credit_d      = r_credit;
    w_vend_valid_d  = 1'b0;
    w_vend_idx_d    = r_vend_idx;
    w_short_err_d   = 1'b0;
    w_coin_reject_d = 1'b0;
    w_chg_valid_d   = r_chg_valid;
    w_chg_coin_d    = r_chg_coin;
    case (r_state)
      ST_CREDIT: begin
        w_chg_valid_d = 1'b0;
        w_chg_coin_d  = '0;
        if (cancel) begin
          w_coin_reject_d = coin_valid;
          if (r_credit != '0) begin
            w_state_d     = ST_CHANGE;
            w_chg_valid_d = 1'b1;
            w_chg_coin_d  = f_coin_for(r_credit);
          end
        end else if (sel_valid) begin
          w_coin_reject_d = coin_valid;
          if (!w_idx_ok[sel_idx] || (r_credit < w_price)) begin
            w_short_err_d = 1'b1;
          end else begin
            w_vend_valid_d = 1'b1;
            w_vend_idx_d   = sel_idx;
            w_credit_d     = w_after_vend;
            if (w_after_vend != '0) begin
              w_state_d     = ST_CHANGE;
              w_chg_valid_d = 1'b1;
              w_chg_coin_d  = f_coin_for(w_after_vend);
            end
          end
        end else if (coin_valid) begin
          if (w_sum <= c_max_credit) w_credit_d = w_sum[W-1:0];
          else                       w_coin_reject_d = 1'b1;
        end
      end
      ST_CHANGE: begin
        w_coin_reject_d = coin_valid;
        if (r_chg_valid && chg_ready) begin
          w_credit_d = w_after_chg;
          if (w_after_chg == '0) begin
            w_state_d     = ST_CREDIT;
            w_chg_valid_d = 1'b0;
            w_chg_coin_d  = '0;
          end else begin
            w_chg_coin_d  = f_coin_for(w_after_chg);
          end
        end
      end
      default: w_state_d = ST_CREDIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_CREDIT;
      r_credit      <= '0;
      r_vend_valid  <= 1'b0;
      r_vend_idx    <= '0;
      r_short_err   <= 1'b0;
      r_coin_reject <= 1'b0;
      r_chg_valid   <= 1'b0;
      r_chg_coin    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_credit      <= w_credit_d;
      r_vend_valid  <= w_vend_valid_d;
      r_vend_idx    <= w_vend_idx_d;
      r_short_err   <= w_short_err_d;
      r_coin_reject <= w_coin_reject_d;
      r_chg_valid   <= w_chg_valid_d;
      r_chg_coin    <= w_chg_coin_d;
    end
  end

  assign credit      = r_credit;
  assign vend_valid  = r_vend_valid;
  assign vend_idx    = r_vend_idx;
  assign short_err   = r_short_err;
  assign coin_reject = r_coin_reject;
  assign chg_valid   = r_chg_valid;
  assign chg_coin    = r_chg_coin;

endmodule
`default_nettype wire

// File: tb/tb_vend_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_credit_fsm
// Brief    : Directed self-checking bench for vend_credit_fsm (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_credit_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_val = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_idx = '0;
  logic       cancel = 1'b0;
  logic       chg_ready = 1'b0;
  logic [7:0] credit;
  logic       vend_valid;
  logic [1:0] vend_idx;
  logic       short_err;
  logic       coin_reject;
  logic       chg_valid;
  logic [7:0] chg_coin;

  int n_total = 0;
  int n_bad   = 0;

  vend_credit_fsm #(
    .W(8), .NPROD(4), .PRICES({8'd7, 8'd5, 8'd3, 8'd2}),
    .MAX_CREDIT(20), .CHG_BIG(5)
  ) u_dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_idx(sel_idx),
    .cancel(cancel), .chg_ready(chg_ready),
    .credit(credit), .vend_valid(vend_valid), .vend_idx(vend_idx),
    .short_err(short_err), .coin_reject(coin_reject),
    .chg_valid(chg_valid), .chg_coin(chg_coin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    tick();
    coin_valid = 1'b0;
    coin_val   = '0;
  endtask

  task automatic put_sel(input logic [1:0] idx);
    sel_valid = 1'b1;
    sel_idx   = idx;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic put_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  // Pay out everything with the hopper always ready; bounded wait.
  task automatic drain(input string tag);
    chg_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!chg_valid) break;
      tick();
    end
    chg_ready = 1'b0;
    check({tag, "_chg_valid"}, 32'(chg_valid), 0);
    check({tag, "_credit"}, 32'(credit), 0);
  endtask

  initial begin
    #2;
    check("rst_credit", 32'(credit), 0);
    check("rst_chg_valid", 32'(chg_valid), 0);
    check("rst_chg_coin", 32'(chg_coin), 0);
    check("rst_vend", 32'(vend_valid), 0);
    check("rst_vend_idx", 32'(vend_idx), 0);
    #10 reset = 1'b0;
    tick();

    // Coins 2,5,5 then buy product 3 (price 7)
    put_coin(8'd2);  check("t1_c2", 32'(credit), 2);
    put_coin(8'd5);  check("t1_c7", 32'(credit), 7);
    put_coin(8'd5);  check("t1_c12", 32'(credit), 12);
    put_sel(2'd3);
    check("t1_vend", 32'(vend_valid), 1);
    check("t1_vidx", 32'(vend_idx), 3);
    check("t1_cred5", 32'(credit), 5);
    check("t1_chgv", 32'(chg_valid), 1);
    check("t1_chgc", 32'(chg_coin), 5);
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    check("t1_vend_pulse", 32'(vend_valid), 0);
    check("t1_paid", 32'(credit), 0);
    check("t1_back", 32'(chg_valid), 0);

    // Insufficient credit
    put_coin(8'd4);  check("t2_c4", 32'(credit), 4);
    put_sel(2'd2);
    check("t2_short", 32'(short_err), 1);
    check("t2_cred", 32'(credit), 4);
    check("t2_novend", 32'(vend_valid), 0);
    tick();
    check("t2_short_pulse", 32'(short_err), 0);
    put_sel(2'd1);   // price 3 -> 1 left, goes to change
    check("t2_vend1", 32'(vend_valid), 1);
    check("t2_chgc1", 32'(chg_coin), 1);
    drain("t2_drain");

    // Ceiling
    put_coin(8'd10);
    put_coin(8'd8);  check("t3_c18", 32'(credit), 18);
    put_coin(8'd5);
    check("t3_rej", 32'(coin_reject), 1);
    check("t3_cred18", 32'(credit), 18);
    put_coin(8'd2);
    check("t3_c20", 32'(credit), 20);
    check("t3_norej", 32'(coin_reject), 0);
    put_cancel();
    drain("t3_drain");

    // Cancel with stalled hopper, then 5,1,1,1
    put_coin(8'd8);
    put_cancel();
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_coin", 32'(chg_coin), 5);
      check("t4_hold_cred", 32'(credit), 8);
      tick();
    end
    check("t4_pay0", 32'(chg_coin), 5);
    chg_ready = 1'b1;
    tick(); check("t4_cr3", 32'(credit), 3); check("t4_pay1", 32'(chg_coin), 1);
    tick(); check("t4_cr2", 32'(credit), 2); check("t4_pay2", 32'(chg_coin), 1);
    tick(); check("t4_cr1", 32'(credit), 1); check("t4_pay3", 32'(chg_coin), 1);
    tick(); check("t4_cr0", 32'(credit), 0); check("t4_done", 32'(chg_valid), 0);
    chg_ready = 1'b0;
    put_coin(8'd1);  check("t4_credit_state", 32'(credit), 1);
    put_cancel();
    drain("t4_drain");

    // Simultaneous cancel + sel + coin at credit 6
    put_coin(8'd6);
    cancel = 1'b1; sel_valid = 1'b1; sel_idx = 2'd0; coin_valid = 1'b1; coin_val = 8'd1;
    tick();
    cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = '0;
    check("t5_chgv", 32'(chg_valid), 1);
    check("t5_rej", 32'(coin_reject), 1);
    check("t5_novend", 32'(vend_valid), 0);
    check("t5_noshort", 32'(short_err), 0);
    check("t5_cred", 32'(credit), 6);
    put_coin(8'd2);
    check("t5_chg_rej", 32'(coin_reject), 1);
    check("t5_chg_cred", 32'(credit), 6);
    put_sel(2'd0);
    check("t5_chg_novend", 32'(vend_valid), 0);
    check("t5_chg_noshort", 32'(short_err), 0);
    drain("t5_drain");

    // Zero-value coin is accepted silently
    put_coin(8'd0);
    check("t6_zero_cred", 32'(credit), 0);
    check("t6_zero_norej", 32'(coin_reject), 0);

    // Async reset mid-change
    put_coin(8'd3);
    put_cancel();
    check("t7_chgv", 32'(chg_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("t7_rst_cred", 32'(credit), 0);
    check("t7_rst_chgv", 32'(chg_valid), 0);
    #2 reset = 1'b0;
    tick();
    check("t7_idle", 32'(chg_valid), 0);
    put_coin(8'd2);
    check("t7_credit_state", 32'(credit), 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
